// File: rtl/fp_pkg.sv
// fp_pkg: shared rounding-mode encodings, fflags bit indices, canonical-NaN helper and per-op status struct (no ports)
package fp_pkg;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} frm_e;
  localparam int NV_B = 4;
  localparam int DZ_B = 3;
  localparam int OF_B = 2;
  localparam int UF_B = 1;
  localparam int NX_B = 0;
  typedef struct packed {
    logic sign;
    frm_e frm;
    logic inv;
    logic dz;
    logic of;
    logic uf;
    logic zero;
  } fp_res_t;
  function automatic logic [63:0] canon_nan(int exp_w, int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction
endpackage

// File: rtl/fp_add_norm_round_pipe_if.sv
// fp_add_norm_round_pipe_if: op bus (in_* valid/ready + exceptions, out_* result/flags, flags_acc/flags_clr); master=producer/consumer side, slave=pipe
interface fp_add_norm_round_pipe_if #(parameter int EXP_W = 8, parameter int FRAC_W = 23);
  logic in_valid, in_ready, in_ovf, in_unf, in_dz, in_inv, in_sign, in_carry;
  logic [2:0] in_frm;
  logic [EXP_W-1:0] in_exp;
  logic [FRAC_W+2:0] in_frac;
  logic out_valid, out_ready, flags_clr;
  logic [EXP_W+FRAC_W:0] out_result;
  logic [4:0] out_flags, flags_acc;
  modport master (
    output in_valid, in_ovf, in_unf, in_dz, in_inv, in_sign, in_carry, in_frm, in_exp, in_frac, out_ready, flags_clr,
    input in_ready, out_valid, out_result, out_flags, flags_acc
  );
  modport slave (
    input in_valid, in_ovf, in_unf, in_dz, in_inv, in_sign, in_carry, in_frm, in_exp, in_frac, out_ready, flags_clr,
    output in_ready, out_valid, out_result, out_flags, flags_acc
  );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter; d = W-bit vector, cnt = zeros above the highest set bit (0 when d is zero)
module fp_lzc #(
  parameter int W = 26,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = d[i] ? CW'(W - 1 - i) : cnt;
  end
endmodule

// File: rtl/fp_add_norm_round_pipe.sv
// fp_add_norm_round_pipe: 2-stage normalise/round/flag pipe; CLK, nRST (async low), bus.slave carries in/out handshakes, result, fflags and sticky flags_acc
module fp_add_norm_round_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input logic CLK,
  input logic nRST,
  fp_add_norm_round_pipe_if.slave bus
);
  localparam int W = FRAC_W + 3;
  localparam int LW = $clog2(W);
  localparam int RW = 1 + EXP_W + FRAC_W;
  localparam logic [63:0] NAN64 = canon_nan(EXP_W, FRAC_W);
  localparam logic [RW-1:0] NAN = NAN64[RW-1:0];
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EBIG = {{(EXP_W-1){1'b1}}, 1'b0};
  logic live, s1_v, s2_v, s1_ld, s2_ld;
  logic [EXP_W-1:0] s1_exp, n_exp, r_exp;
  logic [W-1:0] s1_mant, n_mant;
  fp_res_t s1, n_res;
  logic [LW-1:0] lz;
  logic nz, up, rc, rof, of, inf_sel;
  logic [FRAC_W-1:0] r_frac;
  logic [RW-1:0] res;
  logic [4:0] flg;
  fp_lzc #(.W(W)) u_lzc (.d(bus.in_frac), .cnt(lz));
  assign s2_ld = !s2_v || bus.out_ready;
  // live keeps in_ready low until the first clock after reset release
  assign s1_ld = live && (!s1_v || s2_ld);
  assign bus.in_ready = s1_ld;
  assign bus.out_valid = s2_v;
  always_comb begin
    nz = |bus.in_frac;
    // carry: the carry bit becomes the new hidden bit, the shifted-out bit folds into sticky
    n_mant = bus.in_carry ? {1'b1, bus.in_frac[W-1:2], |bus.in_frac[1:0]} : bus.in_frac << lz;
    n_exp = bus.in_carry ? bus.in_exp + EXP_W'(1) : bus.in_exp - EXP_W'(lz);
    n_res.sign = bus.in_sign;
    n_res.frm = bus.in_frm > 3'd4 ? RNE : frm_e'(bus.in_frm);
    n_res.inv = bus.in_inv;
    n_res.dz = bus.in_dz;
    n_res.of = bus.in_ovf | (bus.in_carry && bus.in_exp == EBIG);
    n_res.uf = bus.in_unf | (!bus.in_carry && nz && int'(bus.in_exp) <= int'(lz));
    n_res.zero = !bus.in_carry && !nz;
  end
  always_comb begin
    up = s1.frm == RTZ ? 1'b0 :
         s1.frm == RDN ? (s1_mant[1] | s1_mant[0]) & s1.sign :
         s1.frm == RUP ? (s1_mant[1] | s1_mant[0]) & ~s1.sign :
         s1.frm == RMM ? s1_mant[1] :
         s1_mant[1] & (s1_mant[0] | s1_mant[2]);
    // an all-ones mantissa rounding up wraps the fraction to zero and bumps the exponent
    rc = up & (&s1_mant[W-1:2]);
    r_frac = s1_mant[W-2:2] + FRAC_W'(up);
    r_exp = s1_exp + EXP_W'(rc);
    rof = rc && r_exp == EMAX && !s1.uf && !s1.zero;
    of = s1.of | rof;
    inf_sel = s1.frm == RNE || s1.frm == RMM || (s1.frm == RDN && s1.sign) || (s1.frm == RUP && !s1.sign);
    res = s1.inv ? NAN :
          of ? (inf_sel ? {s1.sign, EMAX, {FRAC_W{1'b0}}} : {s1.sign, EBIG, {FRAC_W{1'b1}}}) :
          s1.uf ? {s1.sign, {(RW-1){1'b0}}} :
          s1.zero ? {s1.frm == RDN, {(RW-1){1'b0}}} :
          {s1.sign, r_exp, r_frac};
    flg = '0;
    flg[NV_B] = s1.inv;
    flg[DZ_B] = s1.dz;
    flg[OF_B] = of;
    flg[UF_B] = s1.uf;
    flg[NX_B] = of | s1.uf | s1_mant[1] | s1_mant[0];
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      live <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_exp <= '0;
      s1_mant <= '0;
      s1 <= '0;
      bus.out_result <= '0;
      bus.out_flags <= '0;
      bus.flags_acc <= '0;
    end else begin
      live <= 1'b1;
      if (s1_ld) s1_v <= bus.in_valid;
      if (s1_ld && bus.in_valid) begin
        s1_exp <= n_exp;
        s1_mant <= n_mant;
        s1 <= n_res;
      end
      if (s2_ld) s2_v <= s1_v;
      if (s2_ld && s1_v) begin
        bus.out_result <= res;
        bus.out_flags <= flg;
      end
      if (bus.out_valid && bus.out_ready) bus.flags_acc <= bus.flags_clr ? bus.out_flags : bus.flags_acc | bus.out_flags;
      else if (bus.flags_clr) bus.flags_acc <= '0;
    end
endmodule

// File: tb/tb_fp_add_norm_round_pipe.sv
// tb_fp_add_norm_round_pipe: directed vectors with hand-computed results for the normalise/round pipe
module tb_fp_add_norm_round_pipe;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  fp_add_norm_round_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();
  fp_add_norm_round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic drive(input logic s, input logic [7:0] e, input logic c, input logic [25:0] f, input logic [2:0] m, input logic [3:0] x);
    bus.in_valid = 1'b1;
    bus.in_sign = s;
    bus.in_exp = e;
    bus.in_carry = c;
    bus.in_frac = f;
    bus.in_frm = m;
    {bus.in_ovf, bus.in_unf, bus.in_dz, bus.in_inv} = x;
  endtask
  task automatic single(input string tag, input logic s, input logic [7:0] e, input logic c, input logic [25:0] f,
                        input logic [2:0] m, input logic [3:0] x, input logic [31:0] er, input logic [4:0] ef, input logic clr);
    drive(s, e, c, f, m, x);
    @(negedge CLK); chk({tag, ":rdy"}, bus.in_ready, 1);
    @(posedge CLK); #1 bus.in_valid = 1'b0;
    @(negedge CLK); chk({tag, ":lat1"}, bus.out_valid, 0);
    @(negedge CLK); chk({tag, ":vld"}, bus.out_valid, 1);
    chk({tag, ":res"}, bus.out_result, er);
    chk({tag, ":flg"}, bus.out_flags, ef);
    bus.flags_clr = clr;
    @(posedge CLK); #1 bus.flags_clr = 1'b0;
  endtask
  initial begin
    drive(0, 8'h00, 0, 26'h0, 3'd0, 4'h0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.flags_clr = 1'b0;
    #2 nRST = 1'b0;
    #10;
    chk("rst:in_ready", bus.in_ready, 0);
    chk("rst:out_valid", bus.out_valid, 0);
    chk("rst:out_result", bus.out_result, 0);
    chk("rst:out_flags", bus.out_flags, 0);
    chk("rst:flags_acc", bus.flags_acc, 0);
    @(negedge CLK) nRST = 1'b1;
    #1 chk("rst:ready_held", bus.in_ready, 0);
    @(posedge CLK); #1;
    chk("rst:ready_after", bus.in_ready, 1);
    chk("rst:valid_after", bus.out_valid, 0);
    single("add1p1", 0, 8'h7F, 1, 26'h0000000, 3'd0, 4'h0, 32'h40000000, 5'h00, 0);
    single("carry2p5", 0, 8'h7F, 1, 26'h1000000, 3'd0, 4'h0, 32'h40200000, 5'h00, 0);
    single("carrySticky", 0, 8'h7F, 1, 26'h0000003, 3'd3, 4'h0, 32'h40000001, 5'h01, 0);
    single("ofRTZ", 0, 8'hFE, 1, 26'h0000000, 3'd1, 4'h0, 32'h7F7FFFFF, 5'h05, 0);
    single("ofRNE", 0, 8'hFE, 1, 26'h0000000, 3'd0, 4'h0, 32'h7F800000, 5'h05, 0);
    single("ofRUPneg", 1, 8'hFE, 1, 26'h0000000, 3'd3, 4'h0, 32'hFF7FFFFF, 5'h05, 0);
    single("ofRDNneg", 1, 8'hFE, 1, 26'h0000000, 3'd2, 4'h0, 32'hFF800000, 5'h05, 0);
    single("cancRDN", 0, 8'h7F, 0, 26'h0000000, 3'd2, 4'h0, 32'h80000000, 5'h00, 0);
    single("cancRNE", 1, 8'h7F, 0, 26'h0000000, 3'd0, 4'h0, 32'h00000000, 5'h00, 0);
    single("rcRNE", 0, 8'h7F, 0, 26'h3FFFFFE, 3'd0, 4'h0, 32'h40000000, 5'h01, 0);
    single("rcRTZ", 0, 8'h7F, 0, 26'h3FFFFFE, 3'd1, 4'h0, 32'h3FFFFFFF, 5'h01, 0);
    single("lzShift", 0, 8'h80, 0, 26'h0800000, 3'd0, 4'h0, 32'h3F000000, 5'h00, 0);
    single("ufFlush", 1, 8'h05, 0, 26'h0000100, 3'd0, 4'h0, 32'h80000000, 5'h03, 0);
    single("invNaN", 1, 8'h7F, 1, 26'h0000000, 3'd0, 4'h1, 32'h7FC00000, 5'h10, 0);
    single("tieFrm7", 0, 8'h7F, 0, 26'h2000002, 3'd7, 4'h0, 32'h3F800000, 5'h01, 0);
    single("tieRMM", 0, 8'h7F, 0, 26'h2000002, 3'd4, 4'h0, 32'h3F800001, 5'h01, 0);
    bus.out_ready = 1'b0;
    drive(0, 8'h7F, 1, 26'h0000000, 3'd0, 4'h0);
    @(negedge CLK); chk("bp:rdyA", bus.in_ready, 1);
    @(posedge CLK); #1 drive(0, 8'h7F, 0, 26'h2000000, 3'd0, 4'h0);
    @(negedge CLK); chk("bp:rdyB", bus.in_ready, 1);
    @(posedge CLK); #1 drive(0, 8'h80, 0, 26'h3000000, 3'd0, 4'h0);
    @(negedge CLK); chk("bp:stall", bus.in_ready, 0);
    chk("bp:vldA", bus.out_valid, 1);
    chk("bp:resA", bus.out_result, 32'h40000000);
    @(posedge CLK); #1;
    @(negedge CLK); chk("bp:stall2", bus.in_ready, 0);
    chk("bp:holdA", bus.out_result, 32'h40000000);
    bus.out_ready = 1'b1;
    #1 chk("bp:rdyRel", bus.in_ready, 1);
    @(posedge CLK); #1 bus.in_valid = 1'b0;
    @(negedge CLK); chk("bp:vldB", bus.out_valid, 1);
    chk("bp:resB", bus.out_result, 32'h3F800000);
    @(negedge CLK); chk("bp:vldC", bus.out_valid, 1);
    chk("bp:resC", bus.out_result, 32'h40400000);
    @(negedge CLK); chk("bp:drained", bus.out_valid, 0);
    @(posedge CLK); #1 bus.flags_clr = 1'b1;
    @(posedge CLK); #1 bus.flags_clr = 1'b0;
    chk("acc:clr", bus.flags_acc, 0);
    single("accNX", 0, 8'h7F, 0, 26'h3FFFFFE, 3'd0, 4'h0, 32'h40000000, 5'h01, 0);
    chk("acc:nx", bus.flags_acc, 5'h01);
    single("accOF", 0, 8'hFE, 1, 26'h0000000, 3'd0, 4'h0, 32'h7F800000, 5'h05, 0);
    chk("acc:or", bus.flags_acc, 5'h05);
    single("accClrNV", 0, 8'h7F, 0, 26'h2000000, 3'd0, 4'h1, 32'h7FC00000, 5'h10, 1);
    chk("acc:clrHs", bus.flags_acc, 5'h10);
    drive(0, 8'h7F, 1, 26'h0000000, 3'd0, 4'h0);
    @(posedge CLK); #1 drive(0, 8'h7F, 0, 26'h2000000, 3'd0, 4'h0);
    @(posedge CLK); #1 chk("mid:vld", bus.out_valid, 1);
    #1 nRST = 1'b0;
    #1 chk("mid:out_valid", bus.out_valid, 0);
    chk("mid:out_result", bus.out_result, 0);
    chk("mid:out_flags", bus.out_flags, 0);
    chk("mid:flags_acc", bus.flags_acc, 0);
    chk("mid:in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1 chk("mid:ready_after", bus.in_ready, 1);
    @(negedge CLK); chk("mid:flushed1", bus.out_valid, 0);
    @(negedge CLK); chk("mid:flushed2", bus.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
